// File: rtl/axi_byte_fetch.sv
// Fetches len bytes starting at base_addr over an AXI read master, one
// single-beat read at a time, and streams the low byte of each beat out in order.
module axi_byte_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             M_AXI_ARVALID,
    input  logic             M_AXI_ARREADY,
    output logic [31:0]      M_AXI_ARADDR,
    input  logic             M_AXI_RVALID,
    output logic             M_AXI_RREADY,
    input  logic [31:0]      M_AXI_RDATA,
    input  logic [1:0]       M_AXI_RRESP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_r, state_next_s;
    logic             arvalid_r, arvalid_next_s;
    logic [31:0]      araddr_r, araddr_next_s;
    logic             rready_r, rready_next_s;
    logic             busy_r, busy_next_s;
    logic             done_r, done_next_s;
    logic             err_r, err_next_s;
    logic [LEN_W-1:0] len_r, len_next_s;
    logic [LEN_W-1:0] rcv_r, rcv_next_s;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]    count_r, count_next_s;
    logic             push_s, pop_s, space_s;
    logic             unused_rdata_s;

    // Only the low byte of each beat carries data for this stream.
    assign unused_rdata_s = ^M_AXI_RDATA[31:8];

    assign push_s  = M_AXI_RVALID && rready_r;
    assign pop_s   = (count_r != {CW{1'b0}}) && out_ready;
    // Occupancy after this cycle decides whether a new read may be issued,
    // so a beat always has a free slot waiting for it.
    assign space_s = (count_next_s < CW'(FIFO_DEPTH));

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= M_AXI_RDATA[7:0];
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Fetch sequencing: next state and next registered outputs
    always_comb begin
        state_next_s   = state_r;
        arvalid_next_s = arvalid_r;
        araddr_next_s  = araddr_r;
        rready_next_s  = 1'b0;
        busy_next_s    = busy_r;
        done_next_s    = 1'b0;
        err_next_s     = err_r;
        len_next_s     = len_r;
        rcv_next_s     = rcv_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    err_next_s    = 1'b0;
                    araddr_next_s = base_addr;
                    len_next_s    = len;
                    rcv_next_s    = {LEN_W{1'b0}};
                    if (len == {LEN_W{1'b0}}) begin
                        done_next_s = 1'b1;
                    end else begin
                        busy_next_s    = 1'b1;
                        state_next_s   = ADDR;
                        arvalid_next_s = space_s;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR: begin
                if (arvalid_r && M_AXI_ARREADY) begin
                    arvalid_next_s = 1'b0;
                    araddr_next_s  = araddr_r + 32'd1;
                    rready_next_s  = 1'b1;
                    state_next_s   = DATA;
                end else if (!arvalid_r) begin
                    arvalid_next_s = space_s;
                end else begin
                    arvalid_next_s = 1'b1;
                end
            end
            DATA: begin
                rready_next_s = 1'b1;
                if (push_s) begin
                    rready_next_s = 1'b0;
                    rcv_next_s    = rcv_r + LEN_W'(1);
                    if (M_AXI_RRESP != 2'b00) begin
                        err_next_s = 1'b1;
                    end else begin
                        err_next_s = err_r;
                    end
                    if ((rcv_r + LEN_W'(1)) == len_r) begin
                        state_next_s = DRAIN;
                    end else begin
                        state_next_s   = ADDR;
                        arvalid_next_s = space_s;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            DRAIN: begin
                if (count_next_s == {CW{1'b0}}) begin
                    done_next_s  = 1'b1;
                    busy_next_s  = 1'b0;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s   = IDLE;
                arvalid_next_s = 1'b0;
                busy_next_s    = 1'b0;
            end
        endcase
    end

    // Control and AXI output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            arvalid_r <= 1'b0;
            araddr_r  <= 32'h0000_0000;
            rready_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            len_r     <= {LEN_W{1'b0}};
            rcv_r     <= {LEN_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            arvalid_r <= arvalid_next_s;
            araddr_r  <= araddr_next_s;
            rready_r  <= rready_next_s;
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            err_r     <= err_next_s;
            len_r     <= len_next_s;
            rcv_r     <= rcv_next_s;
        end
    end

    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_RREADY  = rready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign out_valid     = (count_r != {CW{1'b0}});
    assign out_data      = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_axi_byte_fetch.sv
// Scoreboard bench for axi_byte_fetch: a slave model serves bytes addr[7:0]^0xB0,
// expected addresses/bytes are queued by the stimulus and checked by a monitor.
module tb_axi_byte_fetch;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        busy, done, err;
    logic        arvalid, arready, rvalid, rready, out_valid;
    logic [31:0] araddr, rdata;
    logic [1:0]  rresp;
    logic [7:0]  out_data;

    logic [31:0] exp_ar[$];
    logic [7:0]  exp_b[$];
    int          total = 0, bad = 0;
    int          stall_req = 0, flush_req = 0;
    int          beats = 0, arv_cycles = 0, stall_cnt = 0, done_cnt = 0;
    logic [31:0] err_addr = 32'h7777_7777;

    always #5 clk = ~clk;

    axi_byte_fetch #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .err(err),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event occurred without an expected entry", nm);
    endtask

    // Slave model and monitor, all on the falling edge
    initial begin
        logic        ar_fire_q = 1'b0, r_fire_q = 1'b0;
        logic [31:0] ar_addr_q = 32'h0;
        int          flush_seen = 0, stall_used = 0;
        arready = 1'b1; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (flush_seen != flush_req) begin
                flush_seen = flush_req;
                rvalid = 1'b0;
            end else begin
                if (r_fire_q) rvalid = 1'b0;
                if (ar_fire_q) begin
                    rvalid = 1'b1;
                    rdata  = {24'hDEAD5A, ar_addr_q[7:0] ^ 8'hB0};
                    rresp  = (ar_addr_q == err_addr) ? 2'b10 : 2'b00;
                end
            end
            if (arvalid && stall_used < stall_req) begin
                arready = 1'b0;
                stall_used++;
                stall_cnt++;
            end else begin
                arready = 1'b1;
            end
            ar_fire_q = arvalid && arready;
            ar_addr_q = araddr;
            r_fire_q  = rvalid && rready;
            if (arvalid) begin
                arv_cycles++;
                if (exp_ar.size() == 0) fail("ar_unexpected");
                else begin
                    chk("araddr", araddr, exp_ar[0]);
                    if (ar_fire_q) void'(exp_ar.pop_front());
                end
            end
            if (r_fire_q) beats++;
            if (out_valid && out_ready) begin
                if (exp_b.size() == 0) fail("byte_unexpected");
                else chk("out_data", {24'h0, out_data}, {24'h0, exp_b.pop_front()});
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [31:0] b, input logic [15:0] l);
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                return;
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic queue_fetch(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = b + 32'(i);
            exp_ar.push_back(a);
            exp_b.push_back(a[7:0] ^ 8'hB0);
        end
    endtask

    task automatic run_basic();
        int d0, cyc;
        queue_fetch(32'h10, 4);
        d0 = done_cnt;
        do_start(32'h10, 16'd4);
        chk("basic_busy", {31'h0, busy}, 32'd1);
        wait_done(40, cyc);
        chk("basic_latency", cyc, 32'd9);
        chk("basic_err", {31'h0, err}, 32'd0);
        @(posedge clk); #1;
        chk("basic_done_1cyc", {31'h0, done}, 32'd0);
        chk("basic_busy_end", {31'h0, busy}, 32'd0);
        chk("basic_done_cnt", done_cnt - d0, 32'd1);
        chk("basic_ar_left", exp_ar.size(), 32'd0);
        chk("basic_b_left", exp_b.size(), 32'd0);
    endtask

    initial begin
        int d0, a0, b0, s0, cyc, busy_seen;
        rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; len = 16'h0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", {31'h0, arvalid}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rready", {31'h0, rready}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_busy_done_err", {29'h0, busy, done, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic four-byte fetch
        run_basic();

        // Zero-length request
        a0 = arv_cycles;
        do_start(32'h200, 16'd0);
        chk("len0_done", {31'h0, done}, 32'd1);
        busy_seen = int'(busy);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | int'(busy);
        end
        chk("len0_busy_never", busy_seen, 32'd0);
        chk("len0_no_ar", arv_cycles - a0, 32'd0);

        // Consumer stalled: only FIFO_DEPTH bytes may be fetched
        out_ready = 1'b0;
        queue_fetch(32'h20, 8);
        b0 = beats; d0 = done_cnt;
        do_start(32'h20, 16'd8);
        repeat (30) @(posedge clk);
        #1;
        chk("stall_beats", beats - b0, 32'd4);
        chk("stall_arvalid", {31'h0, arvalid}, 32'd0);
        chk("stall_busy", {31'h0, busy}, 32'd1);
        out_ready = 1'b1;
        wait_done(60, cyc);
        chk("stall_beats_all", beats - b0, 32'd8);
        chk("stall_b_left", exp_b.size(), 32'd0);
        @(posedge clk); #1;
        chk("stall_done_cnt", done_cnt - d0, 32'd1);

        // ARREADY stall plus an error response on the second beat
        stall_req += 5;
        err_addr = 32'h101;
        queue_fetch(32'h100, 3);
        s0 = stall_cnt;
        do_start(32'h100, 16'd3);
        wait_done(60, cyc);
        chk("arstall_cycles", stall_cnt - s0, 32'd5);
        chk("resp_err", {31'h0, err}, 32'd1);
        chk("resp_b_left", exp_b.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("resp_err_sticky", {31'h0, err}, 32'd1);
        err_addr = 32'h7777_7777;

        // Address wrap and start ignored while busy
        queue_fetch(32'hFFFF_FFFF, 2);
        do_start(32'hFFFF_FFFF, 16'd2);
        chk("wrap_err_cleared", {31'h0, err}, 32'd0);
        do_start(32'h500, 16'd7);
        wait_done(40, cyc);
        chk("wrap_ar_left", exp_ar.size(), 32'd0);
        chk("wrap_b_left", exp_b.size(), 32'd0);
        a0 = arv_cycles;
        repeat (10) @(posedge clk);
        #1;
        chk("ignored_start_no_ar", arv_cycles - a0, 32'd0);
        chk("ignored_start_busy", {31'h0, busy}, 32'd0);

        // Reset in DATA with a beat about to arrive
        out_ready = 1'b0;
        err_addr = 32'h40;
        queue_fetch(32'h40, 4);
        b0 = beats;
        do_start(32'h40, 16'd4);
        for (int i = 0; i < 30; i++) begin
            if ((beats - b0) >= 1 && rready) break;
            @(posedge clk); #1;
        end
        chk("pre_rst_err", {31'h0, err}, 32'd1);
        chk("pre_rst_out_valid", {31'h0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", {31'h0, arvalid}, 32'd0);
        chk("mid_rst_araddr", araddr, 32'd0);
        chk("mid_rst_rready", {31'h0, rready}, 32'd0);
        chk("mid_rst_out", {23'h0, out_valid, out_data}, 32'd0);
        chk("mid_rst_busy_done_err", {29'h0, busy, done, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = beats;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_rready", {31'h0, rready}, 32'd0);
        end
        chk("post_rst_no_beat", beats - b0, 32'd0);
        chk("post_rst_out_valid", {31'h0, out_valid}, 32'd0);
        flush_req++;
        repeat (2) @(posedge clk);
        #1;
        exp_ar.delete();
        exp_b.delete();
        err_addr = 32'h7777_7777;
        out_ready = 1'b1;
        run_basic();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_byte_fetch.md
AXI_BYTE_FETCH -- requirements
Module: axi_byte_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter LEN_W, default 16, width of the transfer length.
REQ-003 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have start  input  1  one-cycle request to begin a fetch.
REQ-006 SHALL have base_addr  input  32  byte address of first byte, sampled on accepted start.
REQ-007 SHALL have len  input  LEN_W  number of bytes to fetch, sampled on accepted start.
REQ-008 SHALL have busy  output  1  high from accepted start until done.
REQ-009 SHALL have done  output  1  one-cycle pulse at fetch completion.
REQ-010 SHALL have err  output  1  sticky flag, any non-OKAY read response in current fetch.
REQ-011 SHALL have M_AXI_ARVALID  output  1, M_AXI_ARREADY  input  1, M_AXI_ARADDR  output  32: AXI read address channel.
REQ-012 SHALL have M_AXI_RVALID  input  1, M_AXI_RREADY  output  1, M_AXI_RDATA  input  32, M_AXI_RRESP  input  2: AXI read data channel.
REQ-013 SHALL have out_valid  output  1, out_ready  input  1, out_data  output  8: byte stream to downstream consumer.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, DRAIN.
REQ-015 SHALL accept start only in IDLE; start while busy is ignored.
REQ-016 On accepted start with len>0: latch base_addr/len, clear err, busy=1, go to ADDR.
REQ-017 On accepted start with len=0: no AR issued, err cleared, done pulses next cycle, busy stays 0.
REQ-018 ADDR: assert ARVALID only when FIFO occupancy < FIFO_DEPTH (space reserved for the beat); ARADDR = base_addr + bytes_issued.
REQ-019 ARVALID and ARADDR SHALL remain stable until ARVALID&&ARREADY; on handshake go to DATA, ARVALID=0 next cycle.
REQ-020 At most one read outstanding at any time.
REQ-021 DATA: RREADY=1; on RVALID&&RREADY push RDATA[7:0] into FIFO (RDATA[31:8] ignored), increment bytes_received.
REQ-022 On that beat: if RRESP!=2'b00 set err (byte still pushed); if bytes_received reaches len go to DRAIN, else ADDR.
REQ-023 RREADY=0 in every state other than DATA.
REQ-024 ARADDR SHALL wrap modulo 2^32 without error.
REQ-025 FIFO: out_valid = not empty, out_data = head entry, pop on out_valid&&out_ready; simultaneous push and pop in one cycle keeps occupancy unchanged.
REQ-026 FIFO push SHALL never occur when full (guaranteed by REQ-018); pop when empty has no effect.
REQ-027 DRAIN: when FIFO empty (including last-byte pop this cycle making it empty), pulse done for one cycle, busy=0, return to IDLE.
REQ-028 Minimum latency with always-ready slave returning RVALID one cycle after AR and out_ready=1: one byte per 2 cycles.
REQ-029 Byte order on out_data SHALL equal address order base_addr, base_addr+1, ..., base_addr+len-1.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, ARVALID=0, ARADDR=0, RREADY=0, out_valid=0, out_data=0, busy=0, done=0, err=0, FIFO empty, counters 0.
REQ-031 Reset mid-fetch SHALL abandon the fetch; an in-flight R beat after reset release is not accepted (RREADY=0 in IDLE).

Verification
REQ-032 base_addr=0x10, len=4, memory bytes 0xA0..0xA3, slave ARREADY=1, out_ready=1 -> ARADDR 0x10,0x11,0x12,0x13 in order, out_data A0,A1,A2,A3, one done pulse, err=0.
REQ-033 len=0 start -> no ARVALID ever, done one cycle later, busy never 1.
REQ-034 len=8, out_ready=0 throughout -> exactly 4 bytes fetched, ARVALID held low afterward; raise out_ready -> remaining 4 fetched, all 8 bytes in order, done after last pop.
REQ-035 ARREADY held low 5 cycles with ARVALID=1 -> ARADDR constant all 5 cycles; RRESP=2'b10 on second beat -> err=1 until next start, all bytes still delivered.
REQ-036 start pulsed again while busy -> ignored, latched len/base unchanged; base_addr=0xFFFFFFFF, len=2 -> ARADDR 0xFFFFFFFF then 0x00000000.
REQ-037 rst_n asserted during DATA with RVALID pending -> all outputs at reset values immediately, FIFO empty, next start behaves as REQ-032.
